// File: rtl/nco_20hz.sv
// nco_20hz: 32-bit phase accumulator feeding a 14-stage pipelined CORDIC rotator that yields 14-bit quadrature sin/cos.
// Optional macro NCO_PHASE_MOD_EN adds a registered phase_mod_i offset ahead of the fold stage (latency ITER+4 instead of ITER+3).
module nco_20hz #(
  parameter int ACC_W = 32,
  parameter int PH_W  = 16,
  parameter int OUT_W = 14,
  parameter int ITER  = 14
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clken,
  input  logic [ACC_W-1:0] phi_inc_i,
`ifdef NCO_PHASE_MOD_EN
  input  logic [ACC_W-1:0] phase_mod_i,
`endif
  output logic [OUT_W-1:0] fsin_o,
  output logic [OUT_W-1:0] fcos_o,
  output logic             out_valid
);

  localparam int DW  = OUT_W + 3;   // CORDIC x/y width
  localparam int GF  = 2;           // fractional guard bits carried in x/y
  localparam int ZF  = 4;           // fractional bits below the phase LSB in z
  localparam int ZW  = PH_W + ZF;
  localparam int AMP = 4974;        // round(8191 / 1.64676), pre-divided CORDIC gain
`ifdef NCO_PHASE_MOD_EN
  localparam int LAT = ITER + 4;
`else
  localparam int LAT = ITER + 3;
`endif

  localparam logic signed [DW-1:0] X_INIT   = DW'(AMP << GF);
  localparam logic signed [DW:0]   RND_HALF = (DW+1)'(1 << (GF - 1));
  localparam logic signed [DW:0]   SAT_HI   = (DW+1)'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [DW:0]   SAT_LO   = -SAT_HI;

  // atan(2^-i) in units of 2^-20 of a full turn; sized for PH_W = 16, ZF = 4.
  function automatic logic signed [ZW-1:0] atan_lut(input int i);
    case (i)
      0:       atan_lut = ZW'(131072);
      1:       atan_lut = ZW'(77376);
      2:       atan_lut = ZW'(40884);
      3:       atan_lut = ZW'(20753);
      4:       atan_lut = ZW'(10417);
      5:       atan_lut = ZW'(5213);
      6:       atan_lut = ZW'(2607);
      7:       atan_lut = ZW'(1304);
      8:       atan_lut = ZW'(652);
      9:       atan_lut = ZW'(326);
      10:      atan_lut = ZW'(163);
      11:      atan_lut = ZW'(81);
      12:      atan_lut = ZW'(41);
      13:      atan_lut = ZW'(20);
      14:      atan_lut = ZW'(10);
      15:      atan_lut = ZW'(5);
      default: atan_lut = '0;
    endcase
  endfunction

  // Drop the guard bits with round-half-up, then clamp to the symmetric range so -2^(OUT_W-1) never appears.
  function automatic logic [OUT_W-1:0] round_sat(input logic signed [DW-1:0] v);
    logic signed [DW:0] r;
    r = ((DW+1)'(v) + RND_HALF) >>> GF;
    if (r > SAT_HI)
      round_sat = OUT_W'(SAT_HI);
    else if (r < SAT_LO)
      round_sat = OUT_W'(SAT_LO);
    else
      round_sat = r[OUT_W-1:0];
  endfunction

  logic [ACC_W-1:0] acc_q;
  logic [PH_W-1:0]  phase;

  // NOTE: clocked state is always written with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      acc_q <= '0;
    else if (clken)
      acc_q <= acc_q + phi_inc_i;
  end

`ifdef NCO_PHASE_MOD_EN
  logic [PH_W-1:0] phase_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      phase_q <= '0;
    else if (clken)
      phase_q <= PH_W'((acc_q + phase_mod_i) >> (ACC_W - PH_W));
  end

  assign phase = phase_q;
`else
  assign phase = acc_q[ACC_W-1 -: PH_W];
`endif

  // Quadrant = nearest multiple of pi/2; the remainder lands in [-pi/4, pi/4).
  logic [1:0]      fold_quad;
  logic [PH_W-1:0] fold_res;

  assign fold_quad = phase[PH_W-1 -: 2] + {1'b0, phase[PH_W-3]};
  assign fold_res  = phase - {fold_quad, {(PH_W-2){1'b0}}};

  logic signed [DW-1:0] x_q    [0:ITER];
  logic signed [DW-1:0] y_q    [0:ITER];
  logic signed [ZW-1:0] z_q    [0:ITER-1];
  logic [1:0]           quad_q [0:ITER];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the pipeline arrays are plain registers, not RAM, so each element is cleared on reset.
      for (int i = 0; i <= ITER; i++) begin
        x_q[i]    <= '0;
        y_q[i]    <= '0;
        quad_q[i] <= '0;
      end
      for (int i = 0; i < ITER; i++)
        z_q[i] <= '0;
    end else if (clken) begin
      x_q[0]    <= X_INIT;
      y_q[0]    <= '0;
      z_q[0]    <= {fold_res, {ZF{1'b0}}};
      quad_q[0] <= fold_quad;

      for (int i = 0; i < ITER; i++) begin
        quad_q[i+1] <= quad_q[i];
        if (z_q[i][ZW-1]) begin
          x_q[i+1] <= x_q[i] + (y_q[i] >>> i);
          y_q[i+1] <= y_q[i] - (x_q[i] >>> i);
        end else begin
          x_q[i+1] <= x_q[i] - (y_q[i] >>> i);
          y_q[i+1] <= y_q[i] + (x_q[i] >>> i);
        end
      end

      // The residual angle after the last stage is never needed, so z stops one stage early.
      for (int i = 0; i < ITER - 1; i++) begin
        if (z_q[i][ZW-1])
          z_q[i+1] <= z_q[i] + atan_lut(i);
        else
          z_q[i+1] <= z_q[i] - atan_lut(i);
      end
    end
  end

  logic signed [DW-1:0] sw_sin_q;
  logic signed [DW-1:0] sw_cos_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sw_sin_q <= '0;
      sw_cos_q <= '0;
    end else if (clken) begin
      case (quad_q[ITER])
        2'd0: begin
          sw_sin_q <= y_q[ITER];
          sw_cos_q <= x_q[ITER];
        end
        2'd1: begin
          sw_sin_q <= x_q[ITER];
          sw_cos_q <= -y_q[ITER];
        end
        2'd2: begin
          sw_sin_q <= -y_q[ITER];
          sw_cos_q <= -x_q[ITER];
        end
        default: begin
          sw_sin_q <= -x_q[ITER];
          sw_cos_q <= y_q[ITER];
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fsin_o <= '0;
      fcos_o <= '0;
    end else if (clken) begin
      fsin_o <= round_sat(sw_sin_q);
      fcos_o <= round_sat(sw_cos_q);
    end
  end

  // One bit per pipeline stage: marks which stages hold a real sample since reset.
  logic [LAT-1:0] valid_sr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      valid_sr <= '0;
    else if (clken)
      valid_sr <= {valid_sr[LAT-2:0], 1'b1};
  end

  assign out_valid = valid_sr[LAT-1];

endmodule

// File: tb/tb_nco_20hz.sv
// Self-checking bench for nco_20hz: a real-valued sin/cos model feeds a scoreboard queue that is drained as samples emerge.
// Covers reset hold, start-up latency, constant/quadrant/fine increments, clock-enable freeze and asynchronous mid-stream reset.
module tb_nco_20hz;

  localparam int ITER = 14;
`ifdef NCO_PHASE_MOD_EN
  localparam int LAT = ITER + 4;
`else
  localparam int LAT = ITER + 3;
`endif
  localparam real PI = 3.14159265358979323846;
  localparam int  TOL = 3;
  localparam int  AMP = 8191;

  typedef struct {
    int s;
    int c;
  } sample_t;

  logic        clk;
  logic        reset_n;
  logic        clken;
  logic [31:0] phi_inc;
  logic [13:0] fsin;
  logic [13:0] fcos;
  logic        out_valid;
`ifdef NCO_PHASE_MOD_EN
  logic [31:0] phase_mod;
`endif

  nco_20hz dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .clken      (clken),
    .phi_inc_i  (phi_inc),
`ifdef NCO_PHASE_MOD_EN
    .phase_mod_i(phase_mod),
`endif
    .fsin_o     (fsin),
    .fcos_o     (fcos),
    .out_valid  (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks;
  int          errors;
  sample_t     sb_q[$];
  sample_t     last_exp;
  logic [31:0] model_acc;
  int          en_edges;
  bit          seen_valid;

  task automatic check(input string tag, input int got, input int exp, input int tol = 0);
    int d;
    d = got - exp;
    checks++;
    if (d > tol || d < -tol) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (tol %0d) at %0t", tag, got, exp, tol, $time);
    end
  endtask

  function automatic sample_t ref_sample(input logic [31:0] acc);
    sample_t r;
    real     ang;
    ang = 2.0 * PI * real'(int'(acc[31:16])) / 65536.0;
    r.s = int'(real'(AMP) * $sin(ang));
    r.c = int'(real'(AMP) * $cos(ang));
    return r;
  endfunction

  // Holds reset for the given number of cycles, checking the cleared outputs, then releases away from a clock edge.
  task automatic do_reset(input int cycles);
    reset_n = 1'b0;
    clken   = 1'b1;
    repeat (cycles) begin
      @(negedge clk);
      check("rst_sin", $signed(fsin), 0);
      check("rst_cos", $signed(fcos), 0);
      check("rst_valid", int'(out_valid), 0);
    end
    sb_q.delete();
    model_acc  = '0;
    en_edges   = 0;
    seen_valid = 1'b0;
    reset_n    = 1'b1;
  endtask

  task automatic step(input bit en);
    sample_t e;
    int      s_got;
    int      c_got;
    clken = en;
    @(posedge clk);
    if (en) begin
      sb_q.push_back(ref_sample(model_acc));
      model_acc = model_acc + phi_inc;
      en_edges++;
    end
    @(negedge clk);
    s_got = $signed(fsin);
    c_got = $signed(fcos);

    if (seen_valid)
      check("valid_hold", int'(out_valid), 1);
    else begin
      check("valid_timing", int'(out_valid), (en_edges >= LAT) ? 1 : 0);
      seen_valid = out_valid;
    end

    if (en && out_valid) begin
      if (sb_q.size() == 0)
        check("sb_depth", sb_q.size(), 1);
      else begin
        e        = sb_q.pop_front();
        last_exp = e;
        check("sin", s_got, e.s, TOL);
        check("cos", c_got, e.c, TOL);
        check("sin_range", s_got, 0, AMP);
        check("cos_range", c_got, 0, AMP);
        check("power", s_got * s_got + c_got * c_got, AMP * AMP, (AMP * AMP) / 100);
      end
    end else if (!en && seen_valid) begin
      check("hold_sin", s_got, last_exp.s, TOL);
      check("hold_cos", c_got, last_exp.c, TOL);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks     = 0;
    errors     = 0;
    reset_n    = 1'b1;
    clken      = 1'b0;
    phi_inc    = 32'd34;
    model_acc  = '0;
    en_edges   = 0;
    seen_valid = 1'b0;
    last_exp   = '{s: 0, c: 0};
`ifdef NCO_PHASE_MOD_EN
    phase_mod  = '0;
`endif
    #1;

    // Reset hold and start-up latency at a very slow increment, then a mid-stream increment change.
    do_reset(7);
    repeat (LAT + 20) step(1'b1);
    phi_inc = 32'h0080_0000;
    repeat (40) step(1'b1);

    // Zero increment: constant (0, full-scale) output.
    phi_inc = 32'd0;
    do_reset(3);
    repeat (LAT + 20) step(1'b1);

    // Quarter-turn increment: cycles through the four axis points.
    phi_inc = 32'h4000_0000;
    do_reset(3);
    repeat (LAT + 24) step(1'b1);

    // 256-sample period with a 5-cycle clock-enable freeze in the middle; 512 samples total.
    phi_inc = 32'h0100_0000;
    do_reset(3);
    repeat (LAT + 300) step(1'b1);
    repeat (5) step(1'b0);
    repeat (212) step(1'b1);

    // Asynchronous reset between clock edges, then a clean restart from phase 0.
    #2;
    reset_n = 1'b0;
    #1;
    check("async_sin", $signed(fsin), 0);
    check("async_cos", $signed(fcos), 0);
    check("async_valid", int'(out_valid), 0);
    do_reset(4);
    repeat (LAT + 40) step(1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
